qlm_mul_arbiter: RTL

//   Shares one combinational QLM_w4q3 approximate 8x8 signed log multiplier among NREQ requesters.

---
 rtl/qlm_mul_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/qlm_mul_arbiter.sv
// Round-robin arbiter in front of one shared QLM_w4q3 approximate 8x8 signed log multiplier.
// Optional macro QLM_ARB_PIPE2_EN adds a second output register stage (latency 2).
module qlm_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_x,
   input  logic [NREQ*8-1:0] req_y,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [15:0]       res_p,
   output logic [IDW-1:0]    res_id,
   output logic [CNTW-1:0]   op_count
);

   // Log of a magnitude >= 8: {leading-one position, next three bits truncated}
   function automatic logic [5:0] qlm_log(input logic [6:0] m);
      logic [2:0] k;
      logic [6:0] sh;
      k = 3'd3;
      for (int i = 3; i < 7; i++) begin
         if (m[i]) k = 3'(i);
      end
      sh = m >> (k - 3'd3);
      return {k, sh[2:0]};
   endfunction

   function automatic logic [15:0] qlm_mul(input logic [7:0] x, input logic [7:0] y);
      logic [6:0]  mx;
      logic [6:0]  my;
      logic [6:0]  s;
      logic [19:0] lin;
      logic [15:0] mag;
      mx  = x[7] ? ~x[6:0] : x[6:0];
      my  = y[7] ? ~y[6:0] : y[6:0];
      s   = {1'b0, qlm_log(mx)} + {1'b0, qlm_log(my)};
      lin = {16'd0, 1'b1, s[2:0]} << s[6:3];
      mag = lin[18:3];
      if ((mx < 7'd8) || (my < 7'd8)) return 16'd0;
      else if (x[7] ^ y[7])           return ~mag;
      else                            return mag;
   endfunction

   logic [IDW-1:0]  rr_q, rr_d;
   logic [CNTW-1:0] op_count_q, op_count_d;
   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0]  gid_s;
   logic            found_s;
   logic            can_accept_s;
   logic            accept_s;
   logic [15:0]     prod_s;

   // Round-robin search starting at rr_q
   always_comb begin
      grant_s = '0;
      gid_s   = '0;
      found_s = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         int idx;
         idx = (int'(rr_q) + off) % NREQ;
         if (!found_s && req_valid[idx]) begin
            found_s      = 1'b1;
            gid_s        = IDW'(idx);
            grant_s[idx] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign accept_s  = found_s & can_accept_s;
   assign req_ready = accept_s ? grant_s : '0;
   assign prod_s    = qlm_mul(req_x[int'(gid_s)*8 +: 8], req_y[int'(gid_s)*8 +: 8]);

   // Pointer and counter next state
   always_comb begin
      rr_d       = rr_q;
      op_count_d = op_count_q;
      if (accept_s) begin
         rr_d       = IDW'((int'(gid_s) + 1) % NREQ);
         op_count_d = op_count_q + CNTW'(1);
      end else begin
         rr_d       = rr_q;
         op_count_d = op_count_q;
      end
   end

   // Pointer and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q       <= '0;
         op_count_q <= '0;
      end else begin
         rr_q       <= rr_d;
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;

`ifdef QLM_ARB_PIPE2_EN
   logic           s1_full_q, s1_full_d, s2_full_q, s2_full_d;
   logic [15:0]    s1_p_q, s1_p_d, s2_p_q, s2_p_d;
   logic [IDW-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
   logic           advance_s;

   assign advance_s    = ~s2_full_q | res_ready;
   assign can_accept_s = ~s1_full_q | advance_s;

   // Two-stage pipeline next state; stage 1 drains into stage 2 whenever stage 2 frees up
   always_comb begin
      s1_full_d = s1_full_q;
      s1_p_d    = s1_p_q;
      s1_id_d   = s1_id_q;
      s2_full_d = s2_full_q;
      s2_p_d    = s2_p_q;
      s2_id_d   = s2_id_q;
      if (accept_s) begin
         s1_full_d = 1'b1;
         s1_p_d    = prod_s;
         s1_id_d   = gid_s;
      end else if (advance_s) begin
         s1_full_d = 1'b0;
      end else begin
         s1_full_d = s1_full_q;
      end
      if (advance_s) begin
         s2_full_d = s1_full_q;
         s2_p_d    = s1_full_q ? s1_p_q  : s2_p_q;
         s2_id_d   = s1_full_q ? s1_id_q : s2_id_q;
      end else begin
         s2_full_d = s2_full_q;
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_full_q <= 1'b0;
         s1_p_q    <= 16'd0;
         s1_id_q   <= '0;
         s2_full_q <= 1'b0;
         s2_p_q    <= 16'd0;
         s2_id_q   <= '0;
      end else begin
         s1_full_q <= s1_full_d;
         s1_p_q    <= s1_p_d;
         s1_id_q   <= s1_id_d;
         s2_full_q <= s2_full_d;
         s2_p_q    <= s2_p_d;
         s2_id_q   <= s2_id_d;
      end
   end

   assign res_valid = s2_full_q;
   assign res_p     = s2_p_q;
   assign res_id    = s2_id_q;
`else
   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;
   slot_e          slot_q, slot_d;
   logic [15:0]    res_p_q, res_p_d;
   logic [IDW-1:0] res_id_q, res_id_d;

   assign can_accept_s = (slot_q == SLOT_EMPTY) | res_ready;

   // Output slot FSM and data capture
   always_comb begin
      slot_d   = slot_q;
      res_p_d  = accept_s ? prod_s : res_p_q;
      res_id_d = accept_s ? gid_s  : res_id_q;
      case (slot_q)
         SLOT_EMPTY: begin
            if (accept_s) slot_d = SLOT_FULL;
            else          slot_d = SLOT_EMPTY;
         end
         SLOT_FULL: begin
            if (res_ready && !accept_s) slot_d = SLOT_EMPTY;
            else                        slot_d = SLOT_FULL;
         end
         default: slot_d = SLOT_EMPTY;
      endcase
   end

   // Output slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= SLOT_EMPTY;
         res_p_q  <= 16'd0;
         res_id_q <= '0;
      end else begin
         slot_q   <= slot_d;
         res_p_q  <= res_p_d;
         res_id_q <= res_id_d;
      end
   end

   assign res_valid = (slot_q == SLOT_FULL);
   assign res_p     = res_p_q;
   assign res_id    = res_id_q;
`endif

endmodule
